updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 181 ++++++++++++++++++
 tb/tb_updown_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Debounced up/down counter with load, wrap/saturate modes
// and a 7-segment readout of every nibble.
module updown_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                        clk100_i,
  input  logic                        rst_i,
  input  logic [9:0]                  sw_i,
  input  logic [1:0]                  key_i,
  output logic [DATA_WIDTH-1:0]       count_o,
  output logic [9:0]                  ledr_o,
  output logic [7*(DATA_WIDTH/4)-1:0] hex_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int ND = DATA_WIDTH / 4;

  typedef enum logic [1:0] {
    STABLE_HI,
    CHK_LO,
    STABLE_LO,
    CHK_HI
  } deb_e;

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] press;

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_deb
    deb_e          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      press_d = 1'b0;
      unique case (state_q)
        STABLE_HI: begin
          if (!sync2_q[g]) state_d = CHK_LO;
        end
        CHK_LO: begin
          if (sync2_q[g]) begin
            state_d = STABLE_HI;
          end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            state_d = STABLE_LO;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE_LO: begin
          if (sync2_q[g]) state_d = CHK_HI;
        end
        CHK_HI: begin
          if (!sync2_q[g]) begin
            state_d = STABLE_LO;
          end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            state_d = STABLE_HI;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = STABLE_HI;
      endcase
    end

    always_ff @(posedge clk100_i) begin
      if (rst_i) begin
        state_q <= STABLE_HI;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    assign press[g] = press_q;
  end

  logic                  step, load;
  logic                  dir, sat;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic                  at_limit;

  assign step = press[0];
  assign load = press[1];
  assign dir  = sw_i[9];
  assign sat  = sw_i[8];

  if (DATA_WIDTH >= 8) begin : g_ld_ext
    assign load_val = DATA_WIDTH'(sw_i[7:0]);
  end else begin : g_ld_trunc
    assign load_val = sw_i[DATA_WIDTH-1:0];
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    if (load) begin
      count_d = load_val;
      wrap_d  = 1'b0;
    end else if (step) begin
      if (dir) begin
        if (count_q != '0) begin
          count_d = count_q - DATA_WIDTH'(1);
        end else if (!sat) begin
          count_d = '1;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count_q != '1) begin
          count_d = count_q + DATA_WIDTH'(1);
        end else if (!sat) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign at_limit = sat & (dir ? (count_q == '0) : (count_q == '1));
  assign count_o  = count_q;
  assign ledr_o   = {6'b0, at_limit, wrap_q, sat, dir};

  // Active-low segments, bit order gfedcba
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  for (genvar k = 0; k < ND; k++) begin : g_hex
    assign hex_o[7*k +: 7] = seg7(count_q[4*k +: 4]);
  end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter at DATA_WIDTH=8,
// DEB_CYCLES=4 with hand-computed expectations.
module tb_updown_counter;

  localparam int DW  = 8;
  localparam int DEB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    sw;
  logic [1:0]    key;
  logic [DW-1:0] count;
  logic [9:0]    ledr;
  logic [13:0]   hex;

  int vectors = 0;
  int errors  = 0;

  updown_counter #(
    .DATA_WIDTH(DW),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk100_i(clk),
    .rst_i   (rst),
    .sw_i    (sw),
    .key_i   (key),
    .count_o (count),
    .ledr_o  (ledr),
    .hex_o   (hex)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k);
    key[k] = 1'b0;
    tick(10);
    key[k] = 1'b1;
    tick(10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sw  = '0;
    key = 2'b11;
    tick(3);
    vectors++;
    if (count !== 8'h00) begin
      errors++;
      $display("FAIL reset_count got %h want 00", count);
    end
    vectors++;
    if (ledr !== 10'h000) begin
      errors++;
      $display("FAIL reset_ledr got %b want 0", ledr);
    end
    vectors++;
    if (hex !== {7'b1000000, 7'b1000000}) begin
      errors++;
      $display("FAIL reset_hex got %b want 00 glyphs", hex);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_latency;
    key[0] = 1'b0;
    tick(7);
    vectors++;
    if (count !== 8'h00) begin
      errors++;
      $display("FAIL lat_early got %h want 00", count);
    end
    tick(1);
    vectors++;
    if (count !== 8'h01) begin
      errors++;
      $display("FAIL lat_edge got %h want 01", count);
    end
    tick(2);
    key[0] = 1'b1;
    tick(10);
    vectors++;
    if (count !== 8'h01) begin
      errors++;
      $display("FAIL lat_once got %h want 01", count);
    end
    vectors++;
    if (hex !== {7'b1000000, 7'b1111001}) begin
      errors++;
      $display("FAIL lat_hex got %b want 01 glyphs", hex);
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      key[0] = i[0];
      tick(2);
    end
    key[0] = 1'b1;
    tick(10);
    vectors++;
    if (count !== 8'h01) begin
      errors++;
      $display("FAIL bounce got %h want 01", count);
    end
  endtask

  task automatic test_wrap;
    sw = {1'b0, 1'b0, 8'hFF};
    press(1);
    vectors++;
    if (count !== 8'hFF) begin
      errors++;
      $display("FAIL load_ff got %h want ff", count);
    end
    press(0);
    vectors++;
    if (count !== 8'h00 || ledr[2] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up got %h/%b want 00/1", count, ledr[2]);
    end
    sw = {1'b0, 1'b0, 8'h05};
    press(1);
    vectors++;
    if (count !== 8'h05 || ledr[2] !== 1'b0) begin
      errors++;
      $display("FAIL load_clr got %h/%b want 05/0", count, ledr[2]);
    end
    sw = {1'b1, 1'b0, 8'h00};
    press(1);
    press(0);
    vectors++;
    if (count !== 8'hFF || ledr[2] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_dn got %h/%b want ff/1", count, ledr[2]);
    end
  endtask

  task automatic test_saturate;
    sw = {1'b1, 1'b1, 8'h00};
    press(1);
    press(0);
    vectors++;
    if (count !== 8'h00 || ledr !== 10'b0000001011) begin
      errors++;
      $display("FAIL sat_dn got %h/%b want 00/0000001011", count, ledr);
    end
    sw = {1'b0, 1'b1, 8'hFF};
    press(1);
    press(0);
    vectors++;
    if (count !== 8'hFF || ledr !== 10'b0000001010) begin
      errors++;
      $display("FAIL sat_up got %h/%b want ff/0000001010", count, ledr);
    end
    sw = {1'b0, 1'b1, 8'hFE};
    press(1);
    press(0);
    vectors++;
    if (count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_inc got %h want ff", count);
    end
  endtask

  task automatic test_switches;
    for (int i = 0; i < 6; i++) begin
      sw[9] = i[0];
      sw[8] = i[1];
      tick(3);
    end
    vectors++;
    if (count !== 8'hFF) begin
      errors++;
      $display("FAIL sw_idle got %h want ff", count);
    end
  endtask

  task automatic test_back_to_back;
    sw = {1'b0, 1'b0, 8'h3C};
    key = 2'b00;
    tick(10);
    key = 2'b11;
    tick(10);
    vectors++;
    if (count !== 8'h3C) begin
      errors++;
      $display("FAIL both_keys got %h want 3c", count);
    end
    vectors++;
    if (hex !== {7'b0110000, 7'b1000110}) begin
      errors++;
      $display("FAIL hex_3c got %b want 3c glyphs", hex);
    end
  endtask

  task automatic test_reset_abort;
    sw = {1'b0, 1'b0, 8'h00};
    key[0] = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    vectors++;
    if (count !== 8'h00) begin
      errors++;
      $display("FAIL abort_rst got %h want 00", count);
    end
    rst = 1'b0;
    tick(7);
    vectors++;
    if (count !== 8'h00) begin
      errors++;
      $display("FAIL abort_early got %h want 00", count);
    end
    tick(1);
    vectors++;
    if (count !== 8'h01) begin
      errors++;
      $display("FAIL abort_late got %h want 01", count);
    end
    key[0] = 1'b1;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_wrap();
    test_saturate();
    test_switches();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
